// File: rtl/guess_judge_if.sv
// Guess/score bus between guess entry, the judge and the game-mode/display stages.
// The master drives the secret, guess and strobes; the slave (the judge) returns the score and game status.
interface guess_judge_if #(
    parameter int NPEG        = 4,
    parameter int COLOR_W     = 3,
    parameter int MAX_GUESSES = 8
);
    localparam int CW = NPEG * COLOR_W;
    localparam int PW = $clog2(NPEG + 1);
    localparam int GW = $clog2(MAX_GUESSES + 1);

    logic [CW-1:0] secret;
    logic          secret_load;
    logic [CW-1:0] guess;
    logic          submit;
    logic          busy;
    logic          result_valid;
    logic [PW-1:0] exact;
    logic [PW-1:0] partial;
    logic [GW-1:0] guesses_used;
    logic          gameOverW;
    logic          gameOverL;

    modport master (
        output secret, secret_load, guess, submit,
        input  busy, result_valid, exact, partial, guesses_used, gameOverW, gameOverL
    );

    modport slave (
        input  secret, secret_load, guess, submit,
        output busy, result_valid, exact, partial, guesses_used, gameOverW, gameOverL
    );
endinterface

// File: rtl/guess_judge.sv
// Mastermind judge: scores a guess against the latched secret (exact and colour-only pegs) and tracks win/loss.
// Optional macro GUESS_JUDGE_FAST_MATCH_EN collapses the per-colour scan into a single cycle.
module guess_judge #(
    parameter int NPEG        = 4,
    parameter int COLOR_W     = 3,
    parameter int MAX_GUESSES = 8
) (
    input  logic          clk,
    input  logic          reset,
    guess_judge_if.slave  bus
);
    localparam int CW   = NPEG * COLOR_W;
    localparam int PW   = $clog2(NPEG + 1);
    localparam int GW   = $clog2(MAX_GUESSES + 1);
    localparam int NCOL = 1 << COLOR_W;

    typedef enum logic [2:0] {IDLE, EXACT, COLOR, REPORT, WON, LOST} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   secret_q, secret_d;
    logic [CW-1:0]   guess_q, guess_d;
    logic [NPEG-1:0] matched_q, matched_d;
    logic [PW-1:0]   exactAcc_q, exactAcc_d;
    logic [PW-1:0]   partAcc_q, partAcc_d;
    logic [PW-1:0]   exact_q, exact_d;
    logic [PW-1:0]   partial_q, partial_d;
    logic [GW-1:0]   guesses_q, guesses_d;
`ifndef GUESS_JUDGE_FAST_MATCH_EN
    logic [COLOR_W-1:0] colIdx_q, colIdx_d;
`endif

    logic [NPEG-1:0] matchMask;
    logic [PW-1:0]   exactCnt;
    logic [PW-1:0]   colorSum;
    logic [PW-1:0]   partTotal;
    logic            lastColor;

    // min(unmatched secret slots of colour c, unmatched guess slots of colour c); the min makes duplicates score right
    function automatic logic [PW-1:0] colorMin(input logic [CW-1:0] s, input logic [CW-1:0] g,
                                               input logic [NPEG-1:0] m, input logic [COLOR_W-1:0] c);
        logic [PW-1:0] sc;
        logic [PW-1:0] gc;
        sc = '0;
        gc = '0;
        for (int i = 0; i < NPEG; i++) begin
            if (!m[i] && s[i*COLOR_W +: COLOR_W] == c) sc = sc + PW'(1);
            if (!m[i] && g[i*COLOR_W +: COLOR_W] == c) gc = gc + PW'(1);
        end
        return (sc < gc) ? sc : gc;
    endfunction

    always_comb begin
        matchMask = '0;
        exactCnt  = '0;
        for (int i = 0; i < NPEG; i++) begin
            if (guess_q[i*COLOR_W +: COLOR_W] == secret_q[i*COLOR_W +: COLOR_W]) begin
                matchMask[i] = 1'b1;
                exactCnt     = exactCnt + PW'(1);
            end
        end
    end

    always_comb begin
`ifdef GUESS_JUDGE_FAST_MATCH_EN
        colorSum = '0;
        for (int c = 0; c < NCOL; c++) begin
            colorSum = colorSum + colorMin(secret_q, guess_q, matched_q, COLOR_W'(c));
        end
        lastColor = 1'b1;
`else
        colorSum  = colorMin(secret_q, guess_q, matched_q, colIdx_q);
        lastColor = (colIdx_q == COLOR_W'(NCOL - 1));
`endif
        partTotal = partAcc_q + colorSum;
    end

    always_comb begin
        state_d    = state_q;
        secret_d   = secret_q;
        guess_d    = guess_q;
        matched_d  = matched_q;
        exactAcc_d = exactAcc_q;
        partAcc_d  = partAcc_q;
        exact_d    = exact_q;
        partial_d  = partial_q;
        guesses_d  = guesses_q;
`ifndef GUESS_JUDGE_FAST_MATCH_EN
        colIdx_d   = colIdx_q;
`endif
        case (state_q)
            IDLE: begin
                // secret_load outranks submit; a simultaneous submit is simply dropped
                if (bus.secret_load) begin
                    secret_d  = bus.secret;
                    guesses_d = '0;
                    exact_d   = '0;
                    partial_d = '0;
                end else if (bus.submit) begin
                    guess_d   = bus.guess;
                    exact_d   = '0;
                    partial_d = '0;
                    state_d   = EXACT;
                end
            end
            EXACT: begin
                matched_d  = matchMask;
                exactAcc_d = exactCnt;
                partAcc_d  = '0;
`ifndef GUESS_JUDGE_FAST_MATCH_EN
                colIdx_d   = '0;
`endif
                state_d    = COLOR;
            end
            COLOR: begin
                partAcc_d = partTotal;
`ifndef GUESS_JUDGE_FAST_MATCH_EN
                colIdx_d  = colIdx_q + COLOR_W'(1);
`endif
                if (lastColor) begin
                    exact_d   = exactAcc_q;
                    partial_d = partTotal;
                    if (guesses_q != GW'(MAX_GUESSES)) guesses_d = guesses_q + GW'(1);
                    state_d   = REPORT;
                end
            end
            REPORT: begin
                if (exact_q == PW'(NPEG))                state_d = WON;
                else if (guesses_q == GW'(MAX_GUESSES)) state_d = LOST;
                else                                     state_d = IDLE;
            end
            WON:     state_d = WON;
            LOST:    state_d = LOST;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            secret_q   <= '0;
            guess_q    <= '0;
            matched_q  <= '0;
            exactAcc_q <= '0;
            partAcc_q  <= '0;
            exact_q    <= '0;
            partial_q  <= '0;
            guesses_q  <= '0;
`ifndef GUESS_JUDGE_FAST_MATCH_EN
            colIdx_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            secret_q   <= secret_d;
            guess_q    <= guess_d;
            matched_q  <= matched_d;
            exactAcc_q <= exactAcc_d;
            partAcc_q  <= partAcc_d;
            exact_q    <= exact_d;
            partial_q  <= partial_d;
            guesses_q  <= guesses_d;
`ifndef GUESS_JUDGE_FAST_MATCH_EN
            colIdx_q   <= colIdx_d;
`endif
        end
    end

    assign bus.busy         = (state_q == EXACT) || (state_q == COLOR) || (state_q == REPORT);
    assign bus.result_valid = (state_q == REPORT);
    assign bus.exact        = exact_q;
    assign bus.partial      = partial_q;
    assign bus.guesses_used = guesses_q;
    assign bus.gameOverW    = (state_q == WON);
    assign bus.gameOverL    = (state_q == LOST);
endmodule
